// File: rtl/multicycle_control_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit
// Brief    : Moore FSM sequencing the per-cycle strobes of a multicycle MIPS
//            datapath, with optional memory wait states and jump support.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
    parameter int OPCODE_W      = 6,
    parameter int ALUOP_W       = 2,
    parameter int MEM_HANDSHAKE = 1,
    parameter int JUMP_EN       = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic [1:0]          PCSource,
    output logic                illegal_op,
    output logic                instr_done,
    output logic [3:0]          state
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_RTEXEC   = 4'd7,
        S_RTWB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_ADDIEXEC = 4'd10,
        S_ADDIWB   = 4'd11,
        S_JUMP     = 4'd12
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = ALUOP_W'(2'b00);
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = ALUOP_W'(2'b01);
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = ALUOP_W'(2'b10);

    state_t state_q;
    state_t state_d;
    state_t decode_next;
    logic   decode_legal;
    logic   mem_done;

    // Without the handshake every memory state completes in a single cycle.
    assign mem_done = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;

    always_comb begin
        decode_next  = S_FETCH;
        decode_legal = 1'b1;
        if (opcode == OP_RTYPE) begin
            decode_next = S_RTEXEC;
        end else if ((opcode == OP_LW) || (opcode == OP_SW)) begin
            decode_next = S_MEMADR;
        end else if (opcode == OP_BEQ) begin
            decode_next = S_BRANCH;
        end else if (opcode == OP_ADDI) begin
            decode_next = S_ADDIEXEC;
        end else if ((JUMP_EN != 0) && (opcode == OP_J)) begin
            decode_next = S_JUMP;
        end else begin
            decode_legal = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    if (mem_done) state_d = S_DECODE;
            S_DECODE:   state_d = decode_next;
            S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    if (mem_done) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWR:    if (mem_done) state_d = S_FETCH;
            S_RTEXEC:   state_d = S_RTWB;
            S_RTWB:     state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_ADDIEXEC: state_d = S_ADDIWB;
            S_ADDIWB:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobes decode from the current state; only the memory-completion
    // qualifiers (fetch commit, store retire) look at mem_ready directly.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = ALUOP_ADD;
        PCSource    = 2'b00;
        illegal_op  = 1'b0;
        instr_done  = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_done;
                PCWrite = mem_done;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                illegal_op = ~decode_legal;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_done;
            end
            S_RTEXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_RTWB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
            end
            S_ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = ALUOP_ADD;
            end
            S_ADDIWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
            end
            default: begin
                PCWrite = 1'b0;
            end
        endcase
    end

    assign state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control_unit
// Brief    : Directed-vector bench for the multicycle control FSM; three
//            instances cover the default, no-handshake and no-jump builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;

    // Control word: PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,
    // RegDst,RegWrite,ALUSrcA,ALUSrcB[2],ALUOp[2],PCSource[2],illegal_op,instr_done
    localparam logic [17:0] C_ZERO    = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] C_FETCH   = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] C_FWAIT   = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] C_DECODE  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
    localparam logic [17:0] C_DEC_ILL = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_1_0;
    localparam logic [17:0] C_MEMADR  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [17:0] C_MEMRD   = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] C_MEMWB   = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_0_1;
    localparam logic [17:0] C_MEMWR_W = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] C_MEMWR_D = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_1;
    localparam logic [17:0] C_RTEXEC  = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [17:0] C_RTWB    = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_0_1;
    localparam logic [17:0] C_BRANCH  = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_0_1;
    localparam logic [17:0] C_ADDIEX  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [17:0] C_ADDIWB  = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_0_1;
    localparam logic [17:0] C_JUMP    = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_0_1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       mem_ready = 1'b1;
    logic [5:0] opcode = 6'b000000;
    int         errors = 0;
    int         checks = 0;

    wire [2:0]      pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, ill, done;
    wire [2:0][1:0] asb, aop, pcs;
    wire [2:0][3:0] st;

    always #5 clk = ~clk;

    // Instance 0: default build, 1: MEM_HANDSHAKE=0, 2: JUMP_EN=0.
    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            multicycle_control_unit #(
                .OPCODE_W      (6),
                .ALUOP_W       (2),
                .MEM_HANDSHAKE ((g == 1) ? 0 : 1),
                .JUMP_EN       ((g == 2) ? 0 : 1)
            ) u_dut (
                .clk         (clk),
                .rst_n       (rst_n),
                .opcode      (opcode),
                .mem_ready   (mem_ready),
                .PCWrite     (pcw[g]),
                .PCWriteCond (pcwc[g]),
                .IorD        (iord[g]),
                .MemRead     (mr[g]),
                .MemWrite    (mw[g]),
                .IRWrite     (irw[g]),
                .MemtoReg    (m2r[g]),
                .RegDst      (rdst[g]),
                .RegWrite    (rw[g]),
                .ALUSrcA     (asa[g]),
                .ALUSrcB     (asb[g]),
                .ALUOp       (aop[g]),
                .PCSource    (pcs[g]),
                .illegal_op  (ill[g]),
                .instr_done  (done[g]),
                .state       (st[g])
            );
        end
    endgenerate

    function automatic logic [17:0] ctl(input int k);
        return {pcw[k], pcwc[k], iord[k], mr[k], mw[k], irw[k], m2r[k], rdst[k],
                rw[k], asa[k], asb[k], aop[k], pcs[k], ill[k], done[k]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        opcode = 6'b100011;
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (st[k] !== 4'd0 || ctl(k) !== C_ZERO) begin
                    errors++;
                    $display("FAIL reset_hold inst%0d cyc%0d: state=%0d ctl=%b, want state=0 ctl=%b",
                             k, c, st[k], ctl(k), C_ZERO);
                end
            end
        end
        rst_n = 1'b1;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (st[0] !== 4'd0) begin
            errors++;
            $display("FAIL reset_release_no_edge: state=%0d, want 0", st[0]);
        end
        tick();
        checks++;
        if (st[0] !== 4'd1 || ctl(0) !== C_FETCH) begin
            errors++;
            $display("FAIL reset_first_edge: state=%0d ctl=%b, want state=1 ctl=%b", st[0], ctl(0), C_FETCH);
        end
    endtask

    task automatic test_lw();
        logic [3:0]  es [6];
        logic [17:0] ec [6];
        logic [5:0]  eo [6];
        es = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1};
        ec = '{C_FETCH, C_DECODE, C_MEMADR, C_MEMRD, C_MEMWB, C_FETCH};
        // opcode is junk outside DECODE/MEMADR to show it is ignored there
        eo = '{6'b111111, 6'b100011, 6'b100011, 6'b000000, 6'b000010, 6'b111111};
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            opcode = eo[i];
            #1;
            checks++;
            if (st[0] !== es[i] || ctl(0) !== ec[i]) begin
                errors++;
                $display("FAIL lw step%0d: state=%0d ctl=%b, want state=%0d ctl=%b", i, st[0], ctl(0), es[i], ec[i]);
            end
            if (i < 5) tick();
        end
    endtask

    task automatic test_sw_wait();
        logic [3:0]  es [7];
        logic [17:0] ec [7];
        logic        er [7];
        es = '{4'd1, 4'd2, 4'd3, 4'd6, 4'd6, 4'd6, 4'd1};
        ec = '{C_FETCH, C_DECODE, C_MEMADR, C_MEMWR_W, C_MEMWR_W, C_MEMWR_D, C_FETCH};
        er = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        opcode = 6'b101011;
        for (int i = 0; i < 7; i++) begin
            mem_ready = er[i];
            #1;
            checks++;
            if (st[0] !== es[i] || ctl(0) !== ec[i]) begin
                errors++;
                $display("FAIL sw_wait step%0d: state=%0d ctl=%b, want state=%0d ctl=%b", i, st[0], ctl(0), es[i], ec[i]);
            end
            if (i < 6) tick();
        end
    endtask

    task automatic test_fetch_wait_rtype();
        logic [3:0]  es [9];
        logic [17:0] ec [9];
        logic        er [9];
        es = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd7, 4'd8, 4'd1};
        ec = '{C_FWAIT, C_FWAIT, C_FWAIT, C_FWAIT, C_FETCH, C_DECODE, C_RTEXEC, C_RTWB, C_FETCH};
        er = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        opcode = 6'b000000;
        for (int i = 0; i < 9; i++) begin
            mem_ready = er[i];
            #1;
            checks++;
            if (st[0] !== es[i] || ctl(0) !== ec[i]) begin
                errors++;
                $display("FAIL fetch_wait_rtype step%0d: state=%0d ctl=%b, want state=%0d ctl=%b", i, st[0], ctl(0), es[i], ec[i]);
            end
            if (i < 8) tick();
        end
    endtask

    task automatic test_branch();
        logic [3:0]  es [4];
        logic [17:0] ec [4];
        es = '{4'd1, 4'd2, 4'd9, 4'd1};
        ec = '{C_FETCH, C_DECODE, C_BRANCH, C_FETCH};
        opcode = 6'b000100;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (st[0] !== es[i] || ctl(0) !== ec[i]) begin
                errors++;
                $display("FAIL branch step%0d: state=%0d ctl=%b, want state=%0d ctl=%b", i, st[0], ctl(0), es[i], ec[i]);
            end
            if (i < 3) tick();
        end
    endtask

    task automatic test_addi();
        logic [3:0]  es [5];
        logic [17:0] ec [5];
        es = '{4'd1, 4'd2, 4'd10, 4'd11, 4'd1};
        ec = '{C_FETCH, C_DECODE, C_ADDIEX, C_ADDIWB, C_FETCH};
        opcode = 6'b001000;
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (st[0] !== es[i] || ctl(0) !== ec[i]) begin
                errors++;
                $display("FAIL addi step%0d: state=%0d ctl=%b, want state=%0d ctl=%b", i, st[0], ctl(0), es[i], ec[i]);
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_illegal();
        logic [3:0]  es [3];
        logic [17:0] ec [3];
        es = '{4'd1, 4'd2, 4'd1};
        ec = '{C_FETCH, C_DEC_ILL, C_FETCH};
        opcode = 6'b111111;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (st[0] !== es[i] || ctl(0) !== ec[i]) begin
                errors++;
                $display("FAIL illegal step%0d: state=%0d ctl=%b, want state=%0d ctl=%b", i, st[0], ctl(0), es[i], ec[i]);
            end
            if (i < 2) tick();
        end
    endtask

    task automatic test_jump();
        logic [3:0]  es0 [4];
        logic [17:0] ec0 [4];
        logic [3:0]  es2 [4];
        logic [17:0] ec2 [4];
        es0 = '{4'd1, 4'd2, 4'd12, 4'd1};
        ec0 = '{C_FETCH, C_DECODE, C_JUMP, C_FETCH};
        es2 = '{4'd1, 4'd2, 4'd1, 4'd2};
        ec2 = '{C_FETCH, C_DEC_ILL, C_FETCH, C_DEC_ILL};
        opcode = 6'b000010;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (st[0] !== es0[i] || ctl(0) !== ec0[i]) begin
                errors++;
                $display("FAIL jump step%0d: state=%0d ctl=%b, want state=%0d ctl=%b", i, st[0], ctl(0), es0[i], ec0[i]);
            end
            checks++;
            if (st[2] !== es2[i] || ctl(2) !== ec2[i]) begin
                errors++;
                $display("FAIL jump_disabled step%0d: state=%0d ctl=%b, want state=%0d ctl=%b", i, st[2], ctl(2), es2[i], ec2[i]);
            end
            if (i < 3) tick();
        end
    endtask

    task automatic test_no_handshake();
        logic [3:0]  es1 [6];
        logic [17:0] ec1 [6];
        es1 = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1};
        ec1 = '{C_FETCH, C_DECODE, C_MEMADR, C_MEMRD, C_MEMWB, C_FETCH};
        do_reset();
        opcode = 6'b100011;
        mem_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (st[1] !== es1[i] || ctl(1) !== ec1[i]) begin
                errors++;
                $display("FAIL no_handshake step%0d: state=%0d ctl=%b, want state=%0d ctl=%b", i, st[1], ctl(1), es1[i], ec1[i]);
            end
            checks++;
            if (st[0] !== 4'd1 || ctl(0) !== C_FWAIT) begin
                errors++;
                $display("FAIL handshake_hold step%0d: state=%0d ctl=%b, want state=1 ctl=%b", i, st[0], ctl(0), C_FWAIT);
            end
            if (i < 5) tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        opcode = 6'b000000;
        mem_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (st[0] !== 4'd7 || ctl(0) !== C_RTEXEC) begin
            errors++;
            $display("FAIL reset_mid_pre: state=%0d ctl=%b, want state=7 ctl=%b", st[0], ctl(0), C_RTEXEC);
        end
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (st[k] !== 4'd0 || ctl(k) !== C_ZERO) begin
                errors++;
                $display("FAIL reset_mid_async inst%0d: state=%0d ctl=%b, want state=0 ctl=%b", k, st[k], ctl(k), C_ZERO);
            end
        end
        tick();
        checks++;
        if (st[0] !== 4'd0 || ctl(0) !== C_ZERO) begin
            errors++;
            $display("FAIL reset_mid_hold: state=%0d ctl=%b, want state=0 ctl=%b", st[0], ctl(0), C_ZERO);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (st[0] !== 4'd1 || ctl(0) !== C_FETCH) begin
            errors++;
            $display("FAIL reset_mid_restart: state=%0d ctl=%b, want state=1 ctl=%b", st[0], ctl(0), C_FETCH);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_fetch_wait_rtype();
        test_branch();
        test_addi();
        test_illegal();
        test_jump();
        test_no_handshake();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore FSM control unit for the multicycle MIPS datapath. Successor to the single-cycle opcode decoder.
- Sequences each instruction over 3–5+ cycles and drives the per-cycle datapath strobes: PC, IR, memory, register file, ALU muxes.
- Adds an optional memory wait-state handshake, an optional jump instruction, illegal-opcode detection and an instruction-retire pulse.
- Sits between the instruction register opcode field and the shared-memory multicycle datapath.

Parameters:
- OPCODE_W, 6, width of opcode input.
- ALUOP_W, 2, width of ALUOp output.
- MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = mem_ready ignored, one cycle per memory state.
- JUMP_EN, 1, 1 = opcode 000010 (j) supported; 0 = j treated as illegal.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  OPCODE_W  IR[31:26], stable from DECODE onward
- mem_ready  in  1  memory access complete this cycle
- PCWrite  out  1  unconditional PC write
- PCWriteCond  out  1  PC write if ALU zero
- IorD  out  1  memory address mux: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read
- MemWrite  out  1  memory write
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  register-file write data: 0 = ALUOut, 1 = MDR
- RegDst  out  1  destination register: 0 = rt, 1 = rd
- RegWrite  out  1  register-file write
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = A
- ALUSrcB  out  2  ALU B input: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- ALUOp  out  ALUOP_W  00 = add, 01 = sub, 10 = funct
- PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- illegal_op  out  1  one-cycle pulse: unsupported opcode
- instr_done  out  1  one-cycle pulse: instruction retires
- state  out  4  current state, debug

Behaviour:
- State register is the only storage. All outputs decode from state combinationally (Moore), except the wait gating described below.
- Any output not listed for a state is 0.
- rst_n low: state = IDLE (0) immediately; every output 0. First rising edge after release: IDLE -> FETCH.
- FETCH (1): MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
  - With MEM_HANDSHAKE=1 and mem_ready=0: IRWrite and PCWrite are forced 0 and state holds.
  - Advances to DECODE when the fetch completes.
- DECODE (2): ALUSrcB=11 (branch target precompute). Next state by opcode:
  - 000000 -> RTEXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 001000 -> ADDIEXEC
  - 000010 and JUMP_EN=1 -> JUMP
  - any other opcode -> FETCH, with illegal_op=1 during this DECODE cycle.
- MEMADR (3): ALUSrcA=1, ALUSrcB=10. Next state: MEMRD for lw, MEMWR for sw.
- MEMRD (4): MemRead=1, IorD=1. Waits on mem_ready as FETCH does, then -> MEMWB.
- MEMWB (5): RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. -> FETCH.
- MEMWR (6): MemWrite=1, IorD=1.
  - MemWrite stays asserted while waiting for mem_ready.
  - instr_done=1 only in the completing cycle; then -> FETCH.
- RTEXEC (7): ALUSrcA=1, ALUSrcB=00, ALUOp=10. -> RTWB.
- RTWB (8): RegWrite=1, RegDst=1, instr_done=1. -> FETCH.
- BRANCH (9): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1. -> FETCH.
- ADDIEXEC (10): ALUSrcA=1, ALUSrcB=10, ALUOp=00. -> ADDIWB.
- ADDIWB (11): RegWrite=1, RegDst=0, instr_done=1. -> FETCH.
- JUMP (12): PCWrite=1, PCSource=10, instr_done=1. -> FETCH.
- Unused encodings 13–15 -> FETCH on the next edge, all outputs 0.
- Latency with mem_ready=1 throughout:
  - lw 5 cycles
  - sw 4, R-type 4, addi 4
  - beq 3, j 3
  - Each wait cycle adds 1.
- opcode is only sampled in DECODE and MEMADR. Changes in other states are ignored.
- rst_n asserted mid-instruction: immediate return to IDLE; no partial strobe survives.

Test Plan:
- Reset held 3 cycles, released -> all outputs 0 while low; state 0 -> 1 on first edge; FETCH shows MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
- opcode=100011, mem_ready=1 -> states 1,2,3,4,5,1; instr_done=1 only in state 5, with RegWrite=1 and MemtoReg=1.
- opcode=101011, mem_ready low 2 cycles in MEMWR -> MemWrite=1 for 3 cycles; instr_done pulses once, on the third; then FETCH.
- FETCH with mem_ready=0 for 4 cycles -> state stays 1; IRWrite=0 and PCWrite=0 until mem_ready=1. Repeat with MEM_HANDSHAKE=0 -> advances after 1 cycle.
- opcode=000100 -> states 1,2,9,1; BRANCH shows ALUOp=01, PCWriteCond=1, PCSource=01. opcode=000010 -> state 12 with PCSource=10. With JUMP_EN=0, 000010 -> illegal_op pulse in DECODE, back to FETCH.
- opcode=111111 -> illegal_op=1 for exactly one cycle in DECODE; RegWrite/MemWrite never asserted. rst_n pulsed low during RTEXEC -> outputs 0 asynchronously, restart from IDLE.
